mure_block_packer: RTL

- Retire-side packer that converts up to NRET retired uops per cycle into E-trace instruction blocks: {iaddr, iretire, ilastsize, itype, priv}.
- Accumulates consecutive STD uops in an IDLE/COUNT FSM and closes a block on any non-STD itype, counter saturation or flush.
- Closed blocks are buffered in a DEPTH-entry FIFO and drained over a valid/ready port toward the packet emitter.
- Generalises the single-lane uop path to NRET lanes, with configurable itype width and counter width.

---
 rtl/mure_block_packer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mure_block_packer.sv
// mure_block_packer: retire-side E-trace block packer.
// Up to NRET retired uops per cycle are folded into instruction blocks
// {iaddr, iretire, ilastsize, itype, priv}. Consecutive STD uops extend the
// open block. The block closes on a non-STD itype, on counter saturation or
// on flush. Closed blocks queue in a DEPTH-entry FIFO and drain over a
// valid/ready port.
// Optional build macro MURE_BLOCK_TSTAMP_EN adds time_i/blk_tstamp_o. Each
// pushed block then carries the time_i value from its push cycle.
module mure_block_packer #(
  parameter int NRET        = 2,
  parameter int DEPTH       = 8,
  parameter int XLEN        = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int IRETIRE_LEN = 32,
  parameter int PRIV_LEN    = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NRET-1:0]                uop_valid_i,
  input  logic [NRET*XLEN-1:0]           uop_pc_i,
  input  logic [NRET*ITYPE_LEN-1:0]      uop_itype_i,
  input  logic [NRET-1:0]                uop_compressed_i,
  input  logic [NRET*PRIV_LEN-1:0]       uop_priv_i,
  output logic                           uop_ready_o,
  input  logic                           flush_i,
`ifdef MURE_BLOCK_TSTAMP_EN
  input  logic [63:0]                    time_i,
  output logic [63:0]                    blk_tstamp_o,
`endif
  output logic                           blk_valid_o,
  input  logic                           blk_ready_i,
  output logic [XLEN-1:0]                blk_iaddr_o,
  output logic [IRETIRE_LEN-1:0]         blk_iretire_o,
  output logic                           blk_ilastsize_o,
  output logic [ITYPE_LEN-1:0]           blk_itype_o,
  output logic [PRIV_LEN-1:0]            blk_priv_o,
  output logic [$clog2(DEPTH+1)-1:0]     fill_o
);

  localparam int FILL_W  = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NPUSH   = NRET + 1;
  localparam int PCNT_W  = $clog2(NPUSH + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  localparam logic [ITYPE_LEN-1:0]   ITYPE_STD = '0;
  // Saturation guard: 2^IRETIRE_LEN - 2, so one more 32-bit uop never wraps.
  localparam logic [IRETIRE_LEN-1:0] SAT_LIMIT = {{(IRETIRE_LEN-1){1'b1}}, 1'b0};

  typedef struct packed {
`ifdef MURE_BLOCK_TSTAMP_EN
    logic [63:0]             tstamp;
`endif
    logic [XLEN-1:0]         iaddr;
    logic [IRETIRE_LEN-1:0]  iretire;
    logic                    ilastsize;
    logic [ITYPE_LEN-1:0]    itype;
    logic [PRIV_LEN-1:0]     priv;
  } blk_t;

  // Accumulator and FIFO control state
  logic [0:0]             state;
  logic [XLEN-1:0]        acc_iaddr;
  logic [IRETIRE_LEN-1:0] acc_count;
  logic [PRIV_LEN-1:0]    acc_priv;
  logic                   acc_lastc;
  logic [FILL_W-1:0]      fill;
  logic [PTR_W-1:0]       rptr;
  logic [PTR_W-1:0]       wptr;

  blk_t                   mem [DEPTH];

  // Next-state of the accumulator and the per-cycle push list
  logic [0:0]             nxt_state;
  logic [XLEN-1:0]        nxt_iaddr;
  logic [IRETIRE_LEN-1:0] nxt_count;
  logic [PRIV_LEN-1:0]    nxt_priv;
  logic                   nxt_lastc;
  blk_t                   push_ent [NPUSH];
  logic [PCNT_W-1:0]      push_cnt;
  logic [PTR_W-1:0]       wr_idx [NPUSH];
  logic [PTR_W-1:0]       nxt_wptr;
  logic [PTR_W-1:0]       nxt_rptr;
  logic                   pop;
  blk_t                   head;

  // Admission uses registered occupancy only. This leaves room for the
  // worst-case NRET lane pushes plus one flush push.
  assign uop_ready_o = (int'(DEPTH) - int'(fill)) >= NPUSH;

  assign blk_valid_o = (fill != '0);
  assign pop         = blk_valid_o && blk_ready_i;
  assign head        = mem[rptr];

  // Head fields are forced to zero while empty, so the outputs read zero
  // after reset even though storage is not reset.
  assign blk_iaddr_o     = blk_valid_o ? head.iaddr     : '0;
  assign blk_iretire_o   = blk_valid_o ? head.iretire   : '0;
  assign blk_ilastsize_o = blk_valid_o ? head.ilastsize : 1'b0;
  assign blk_itype_o     = blk_valid_o ? head.itype     : '0;
  assign blk_priv_o      = blk_valid_o ? head.priv      : '0;
`ifdef MURE_BLOCK_TSTAMP_EN
  assign blk_tstamp_o    = blk_valid_o ? head.tstamp    : '0;
`endif
  assign fill_o          = fill;

  // Walk lanes in index order, then apply flush, building the push list
  always_comb begin
    // NOTE: every variable gets a default before any conditional update;
    // a path that leaves one unassigned would infer a latch.
    nxt_state = state;
    nxt_iaddr = acc_iaddr;
    nxt_count = acc_count;
    nxt_priv  = acc_priv;
    nxt_lastc = acc_lastc;
    push_cnt  = '0;
    for (int k = 0; k < NPUSH; k++) push_ent[k] = '0;

    if (uop_ready_o) begin
      for (int k = 0; k < NRET; k++) begin
        if (uop_valid_i[k]) begin
          if (nxt_state == S_IDLE) begin
            nxt_iaddr = uop_pc_i[k*XLEN +: XLEN];
            nxt_priv  = uop_priv_i[k*PRIV_LEN +: PRIV_LEN];
            nxt_count = uop_compressed_i[k] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
            nxt_state = S_COUNT;
          end else begin
            nxt_count = nxt_count +
                        (uop_compressed_i[k] ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2));
          end
          nxt_lastc = uop_compressed_i[k];

          if ((uop_itype_i[k*ITYPE_LEN +: ITYPE_LEN] != ITYPE_STD) ||
              (nxt_count >= SAT_LIMIT)) begin
            push_ent[push_cnt].iaddr     = nxt_iaddr;
            push_ent[push_cnt].iretire   = nxt_count;
            push_ent[push_cnt].ilastsize = ~nxt_lastc;
            push_ent[push_cnt].itype     = uop_itype_i[k*ITYPE_LEN +: ITYPE_LEN];
            push_ent[push_cnt].priv      = nxt_priv;
`ifdef MURE_BLOCK_TSTAMP_EN
            push_ent[push_cnt].tstamp    = time_i;
`endif
            push_cnt  = push_cnt + PCNT_W'(1);
            nxt_state = S_IDLE;
          end
        end
      end

      // Flush closes whatever is still open after the lanes, always as STD.
      if (flush_i && (nxt_state == S_COUNT)) begin
        push_ent[push_cnt].iaddr     = nxt_iaddr;
        push_ent[push_cnt].iretire   = nxt_count;
        push_ent[push_cnt].ilastsize = ~nxt_lastc;
        push_ent[push_cnt].itype     = ITYPE_STD;
        push_ent[push_cnt].priv      = nxt_priv;
`ifdef MURE_BLOCK_TSTAMP_EN
        push_ent[push_cnt].tstamp    = time_i;
`endif
        push_cnt  = push_cnt + PCNT_W'(1);
        nxt_state = S_IDLE;
      end
    end
  end

  // Slot addresses for this cycle's pushes and pointer advance, modulo DEPTH
  always_comb begin
    int idx;
    for (int k = 0; k < NPUSH; k++) begin
      idx = int'(wptr) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      wr_idx[k] = PTR_W'(idx);
    end
    idx = int'(wptr) + int'(push_cnt);
    if (idx >= DEPTH) idx = idx - DEPTH;
    nxt_wptr = PTR_W'(idx);
    nxt_rptr = rptr;
    if (pop) nxt_rptr = (rptr == PTR_W'(DEPTH - 1)) ? '0 : rptr + PTR_W'(1);
  end

  // Accumulator, FSM state and FIFO pointers/occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: state registers use non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      state     <= S_IDLE;
      acc_iaddr <= '0;
      acc_count <= '0;
      acc_priv  <= '0;
      acc_lastc <= 1'b0;
      fill      <= '0;
      rptr      <= '0;
      wptr      <= '0;
    end else begin
      state     <= nxt_state;
      acc_iaddr <= nxt_iaddr;
      acc_count <= nxt_count;
      acc_priv  <= nxt_priv;
      acc_lastc <= nxt_lastc;
      fill      <= fill + FILL_W'(push_cnt) - FILL_W'(pop);
      rptr      <= nxt_rptr;
      wptr      <= nxt_wptr;
    end
  end

  // FIFO storage writes, in lane order with the flush entry last
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; occupancy alone decides
    // validity and the head outputs are masked while empty.
    for (int k = 0; k < NPUSH; k++) begin
      if (PCNT_W'(k) < push_cnt) mem[wr_idx[k]] <= push_ent[k];
    end
  end

endmodule
